// File: rtl/aes_stream_pkg.sv
// Shared constants for the AES stream front-end: block width, FSM state codes, beat-width helpers.
package aes_stream_pkg;

    localparam int AES_BLK_W = 128;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    function automatic int beats(input int dw);
        return AES_BLK_W / dw;
    endfunction

    function automatic bit dw_legal(input int dw);
        return (dw == 8) || (dw == 16) || (dw == 32) || (dw == 64) || (dw == 128);
    endfunction

    // A single-beat block still needs a 1-bit counter so the port-free logic stays uniform.
    function automatic int cnt_width(input int dw);
        return (beats(dw) > 1) ? $clog2(beats(dw)) : 1;
    endfunction

endpackage

// File: rtl/aes_stream_shreg.sv
// Parallel-load / DW-bit left-shift register used for the PT, KEY and CT block buffers.
module aes_stream_shreg
    import aes_stream_pkg::*;
#(
    parameter int W  = AES_BLK_W,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic          shift,
    input  logic [DW-1:0] shift_in,
    output logic [W-1:0]  q
);

    logic [W-1:0] shifted;

    generate
        if (DW == W) begin : g_full
            assign shifted = shift_in;
        end else begin : g_part
            assign shifted = {q[W-DW-1:0], shift_in};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Stream front-end for a 128-bit AES core: DW-bit PT/KEY beats in, one core launch, DW-bit CT beats out.
// Optional AES_STREAM_KEY_REUSE_EN adds key_load so a block may reuse the previously loaded key.
module aes_stream_ctrl
    import aes_stream_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [DW-1:0]        PT,
    input  logic [DW-1:0]        KEY,
`ifdef AES_STREAM_KEY_REUSE_EN
    input  logic                 key_load,
`endif
    output logic                 ready,
    output logic                 ct_valid,
    output logic [DW-1:0]        CT,
    input  logic                 ct_ready,
    output logic                 busy,
    output logic                 core_start,
    output logic [AES_BLK_W-1:0] core_pt,
    output logic [AES_BLK_W-1:0] core_key,
    input  logic                 core_done,
    input  logic [AES_BLK_W-1:0] core_ct
);

    localparam int BEATS = beats(DW);
    localparam int CW    = cnt_width(DW);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    generate
        if (!dw_legal(DW)) begin : g_bad_dw
            $error("aes_stream_ctrl: DW must be one of 8, 16, 32, 64, 128");
        end
    endgenerate

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic                 in_fire;
    logic                 out_fire;
    logic                 last_beat;
    logic                 key_shift;
    logic                 ct_load;
    logic [AES_BLK_W-1:0] ct_q;

    assign ready      = reset && (state == S_LOAD);
    assign ct_valid   = (state == S_DRAIN);
    assign core_start = (state == S_START);
    assign busy       = (state != S_LOAD);
    assign in_fire    = valid && ready;
    assign out_fire   = ct_valid && ct_ready;
    assign last_beat  = (cnt == LAST);
    assign ct_load    = (state == S_WAIT) && core_done;
    assign CT         = ct_q[AES_BLK_W-1 -: DW];

`ifdef AES_STREAM_KEY_REUSE_EN
    // key_load is only meaningful on the first beat; later beats follow the latched choice.
    logic key_sel;

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_sel <= 1'b1;
        end else if (in_fire && (cnt == '0)) begin
            key_sel <= key_load;
        end
    end

    assign key_shift = in_fire && ((cnt == '0) ? key_load : key_sel);
`else
    assign key_shift = in_fire;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_LOAD;
            cnt   <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= S_START;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (core_done) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= S_LOAD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    aes_stream_shreg #(.W(AES_BLK_W), .DW(DW)) u_pt_reg (
        .clk(clk), .reset(reset), .load(1'b0), .load_data('0),
        .shift(in_fire), .shift_in(PT), .q(core_pt)
    );

    aes_stream_shreg #(.W(AES_BLK_W), .DW(DW)) u_key_reg (
        .clk(clk), .reset(reset), .load(1'b0), .load_data('0),
        .shift(key_shift), .shift_in(KEY), .q(core_key)
    );

    aes_stream_shreg #(.W(AES_BLK_W), .DW(DW)) u_ct_reg (
        .clk(clk), .reset(reset), .load(ct_load), .load_data(core_ct),
        .shift(out_fire), .shift_in('0), .q(ct_q)
    );

    // Only the top beat of the CT buffer leaves the block; the rest exists to be shifted up.
    generate
        if (DW < AES_BLK_W) begin : g_ct_tail
            logic unused_ct_tail;
            assign unused_ct_tail = ^ct_q[AES_BLK_W-DW-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Testbench for aes_stream_ctrl: DW=8 and DW=32 instances, a stand-in AES core, block-level reference model.
// Define AES_STREAM_KEY_REUSE_EN to also exercise key_load.
`timescale 1ns/1ps
module tb_aes_stream_ctrl;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_STREAM_KEY_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic         valid8, valid32, ct_ready8, ct_ready32;
    logic [7:0]   pt8, key8, ct8;
    logic [31:0]  pt32, key32, ct32;
    logic         ready8, ready32, ct_valid8, ct_valid32, busy8, busy32;
    logic         core_start8, core_start32;
    logic         core_done8 = 1'b0, core_done32 = 1'b0;
    logic [127:0] core_pt8, core_pt32, core_key8, core_key32;
    logic [127:0] core_ct8 = '0, core_ct32 = '0;
`ifdef AES_STREAM_KEY_REUSE_EN
    logic         key_load8, key_load32;
`endif

    bit           inject8 = 1'b0, inject32 = 1'b0;
    int           lat8 = 0, lat32 = 0;
    logic [127:0] lpt8, lkey8, lpt32, lkey32;
    int           starts8 = 0, starts32 = 0;
    int           compared, mismatched;
    logic [127:0] key_eff [2];

    aes_stream_ctrl #(.DW(8)) u_dut8 (
        .clk(clk), .reset(reset), .valid(valid8), .PT(pt8), .KEY(key8),
`ifdef AES_STREAM_KEY_REUSE_EN
        .key_load(key_load8),
`endif
        .ready(ready8), .ct_valid(ct_valid8), .CT(ct8), .ct_ready(ct_ready8),
        .busy(busy8), .core_start(core_start8), .core_pt(core_pt8), .core_key(core_key8),
        .core_done(core_done8), .core_ct(core_ct8)
    );

    aes_stream_ctrl #(.DW(32)) u_dut32 (
        .clk(clk), .reset(reset), .valid(valid32), .PT(pt32), .KEY(key32),
`ifdef AES_STREAM_KEY_REUSE_EN
        .key_load(key_load32),
`endif
        .ready(ready32), .ct_valid(ct_valid32), .CT(ct32), .ct_ready(ct_ready32),
        .busy(busy32), .core_start(core_start32), .core_pt(core_pt32), .core_key(core_key32),
        .core_done(core_done32), .core_ct(core_ct32)
    );

    // Stand-in core: knows the FIPS-197 C.1 answer, otherwise a fixed keyed mix of PT and KEY.
    function automatic logic [127:0] coreFunc(input logic [127:0] p, input logic [127:0] k);
        if (p == C1_PT && k == C1_KEY) return C1_CT;
        return (p ^ {k[63:0], k[127:64]}) + {p[31:0], k[127:32]};
    endfunction

    always @(posedge clk) begin
        core_done8 <= inject8;
        if (inject8) core_ct8 <= {$urandom, $urandom, $urandom, $urandom};
        if (core_start8) begin
            lat8 <= 10; lpt8 <= core_pt8; lkey8 <= core_key8;
        end else if (lat8 > 0) begin
            lat8 <= lat8 - 1;
            if (lat8 == 1) begin core_done8 <= 1'b1; core_ct8 <= coreFunc(lpt8, lkey8); end
        end
        core_done32 <= inject32;
        if (inject32) core_ct32 <= {$urandom, $urandom, $urandom, $urandom};
        if (core_start32) begin
            lat32 <= 10; lpt32 <= core_pt32; lkey32 <= core_key32;
        end else if (lat32 > 0) begin
            lat32 <= lat32 - 1;
            if (lat32 == 1) begin core_done32 <= 1'b1; core_ct32 <= coreFunc(lpt32, lkey32); end
        end
    end

    always @(negedge clk) begin
        if (core_start8)  starts8  <= starts8 + 1;
        if (core_start32) starts32 <= starts32 + 1;
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int beatsOf(input int sel); return (sel != 0) ? 4 : 16; endfunction
    function automatic int widthOf(input int sel); return (sel != 0) ? 32 : 8; endfunction

    function automatic logic [31:0] beatOf(input int sel, input logic [127:0] blk, input int i);
        logic [127:0] s;
        s = blk << (i * widthOf(sel));
        return (sel != 0) ? s[127:96] : {24'h0, s[127:120]};
    endfunction

    function automatic logic gReady(input int sel);   return (sel != 0) ? ready32 : ready8; endfunction
    function automatic logic gCtValid(input int sel); return (sel != 0) ? ct_valid32 : ct_valid8; endfunction
    function automatic logic gBusy(input int sel);    return (sel != 0) ? busy32 : busy8; endfunction
    function automatic logic gStart(input int sel);   return (sel != 0) ? core_start32 : core_start8; endfunction
    function automatic logic gDone(input int sel);    return (sel != 0) ? core_done32 : core_done8; endfunction
    function automatic logic [31:0] gCt(input int sel); return (sel != 0) ? ct32 : {24'h0, ct8}; endfunction
    function automatic logic [127:0] gCorePt(input int sel);  return (sel != 0) ? core_pt32 : core_pt8; endfunction
    function automatic logic [127:0] gCoreKey(input int sel); return (sel != 0) ? core_key32 : core_key8; endfunction

    task automatic setIn(input int sel, input logic v, input logic [31:0] p, input logic [31:0] k, input logic kl);
        if (sel == 0) begin valid8 = v; pt8 = p[7:0]; key8 = k[7:0]; end
        else begin valid32 = v; pt32 = p; key32 = k; end
`ifdef AES_STREAM_KEY_REUSE_EN
        if (sel == 0) key_load8 = kl; else key_load32 = kl;
`endif
    endtask

    task automatic setCtReady(input int sel, input logic r);
        if (sel == 0) ct_ready8 = r; else ct_ready32 = r;
    endtask

    // Feeds one block (or its first stop_after beats) and checks the launch that follows it.
    task automatic applyStimulus(input int sel, input logic [127:0] pt, input logic [127:0] key,
                                 input logic kl, input int gap_at, input int gap_len,
                                 input bit rnd_gaps, input int stop_after);
        int i, gaps, guard, lim;
        i = 0; gaps = 0; guard = 0;
        lim = (stop_after > 0) ? stop_after : beatsOf(sel);
        while (i < lim && guard < 2000) begin
            @(negedge clk);
            guard++;
            if ((i == gap_at && gaps < gap_len) || (rnd_gaps && $urandom_range(3) == 0)) begin
                if (i == gap_at) gaps++;
                setIn(sel, 1'b0, $urandom, $urandom, kl);
            end else begin
                setIn(sel, 1'b1, beatOf(sel, pt, i), beatOf(sel, key, i), kl);
                if (gReady(sel)) i++;
            end
        end
        checkOutput("beats_accepted", i, lim);
        @(negedge clk);
        setIn(sel, 1'b0, '0, '0, kl);
        if (stop_after > 0) return;
        if (kl || !REUSE) key_eff[sel] = key;
        checkOutput("start_pulse", gStart(sel), 1'b1);
        checkOutput("ready_drop", gReady(sel), 1'b0);
        checkOutput("core_pt", gCorePt(sel), pt);
        checkOutput("core_key", gCoreKey(sel), key_eff[sel]);
        @(negedge clk);
        checkOutput("start_one_cycle", gStart(sel), 1'b0);
    endtask

    // mode 0: ct_ready always 1; mode 1: toggles 1/0 each DRAIN cycle; mode 2: random.
    task automatic drainBlock(input int sel, input logic [127:0] exp_ct, input logic [127:0] exp_pt,
                              input int mode);
        int n, guard, nb;
        logic [31:0] prev_ct;
        logic prev_stall, prev_done, tog, rdy;
        n = 0; guard = 0; nb = beatsOf(sel);
        prev_ct = '0; prev_stall = 1'b0; prev_done = 1'b0; tog = 1'b0;
        while (n < nb && guard < 400) begin
            @(negedge clk);
            guard++;
            if (prev_done) checkOutput("ctv_after_done", gCtValid(sel), 1'b1);
            if (gDone(sel)) begin
                checkOutput("ctv_in_wait", gCtValid(sel), 1'b0);
                checkOutput("core_pt_hold", gCorePt(sel), exp_pt);
            end
            prev_done = gDone(sel);
            if (gCtValid(sel)) begin
                if (prev_stall) checkOutput("ct_hold", gCt(sel), prev_ct);
                tog = ~tog;
                rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(1));
                setCtReady(sel, rdy);
                if (rdy) begin
                    checkOutput("ct_beat", gCt(sel), beatOf(sel, exp_ct, n));
                    n++;
                    if (n == nb) setIn(sel, 1'b0, '0, '0, 1'b1);
                end
                prev_stall = !rdy;
                prev_ct = gCt(sel);
            end else begin
                setCtReady(sel, 1'($urandom_range(1)));
                prev_stall = 1'b0;
            end
        end
        checkOutput("ct_beats_seen", n, nb);
        @(negedge clk);
        checkOutput("ready_back", gReady(sel), 1'b1);
        checkOutput("ctv_drop", gCtValid(sel), 1'b0);
        checkOutput("busy_clear", gBusy(sel), 1'b0);
        setCtReady(sel, 1'b1);
    endtask

    task automatic checkResetState();
        for (int s = 0; s < 2; s++) begin
            checkOutput("rst_ready", gReady(s), 1'b0);
            checkOutput("rst_ct_valid", gCtValid(s), 1'b0);
            checkOutput("rst_ct", gCt(s), '0);
            checkOutput("rst_core_start", gStart(s), 1'b0);
            checkOutput("rst_busy", gBusy(s), 1'b0);
            checkOutput("rst_core_pt", gCorePt(s), '0);
            checkOutput("rst_core_key", gCoreKey(s), '0);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkResetState();
        reset = 1'b1;
        key_eff[0] = '0;
        key_eff[1] = '0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s0;
        logic [127:0] p, k;
        logic kl;
        int sel;
        compared = 0;
        mismatched = 0;
        key_eff[0] = '0;
        key_eff[1] = '0;
        setIn(0, 1'b0, '0, '0, 1'b1);
        setIn(1, 1'b0, '0, '0, 1'b1);
        setCtReady(0, 1'b1);
        setCtReady(1, 1'b1);

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        checkResetState();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset8", ready8, 1'b1);
        checkOutput("ready_after_reset32", ready32, 1'b1);

        $display("[TB] DW=8 C.1 back-to-back");
        applyStimulus(0, C1_PT, C1_KEY, 1'b1, -1, 0, 1'b0, 0);
        drainBlock(0, C1_CT, C1_PT, 0);

        $display("[TB] DW=32 C.1 with 3-cycle gap");
        applyStimulus(1, C1_PT, C1_KEY, 1'b1, 2, 3, 1'b0, 0);
        drainBlock(1, C1_CT, C1_PT, 0);

        $display("[TB] DW=8 ct_ready toggling");
        applyStimulus(0, C1_PT, C1_KEY, 1'b1, -1, 0, 1'b0, 0);
        drainBlock(0, C1_CT, C1_PT, 1);

        $display("[TB] reset mid-block");
        s0 = starts8;
        applyStimulus(0, ~C1_PT, ~C1_KEY, 1'b1, -1, 0, 1'b0, 7);
        pulseReset();
        applyStimulus(0, C1_PT, C1_KEY, 1'b1, -1, 0, 1'b0, 0);
        drainBlock(0, C1_CT, C1_PT, 0);
        checkOutput("single_start", starts8 - s0, 1);

        $display("[TB] core_done in LOAD, valid held in WAIT");
        @(negedge clk);
        inject8 = 1'b1; inject32 = 1'b1;
        @(negedge clk);
        inject8 = 1'b0; inject32 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("stray_done_busy8", busy8, 1'b0);
            checkOutput("stray_done_ctv32", ct_valid32, 1'b0);
        end
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(1, p, k, 1'b1, -1, 0, 1'b0, 0);
        setIn(1, 1'b1, $urandom, $urandom, 1'b1);
        drainBlock(1, coreFunc(p, key_eff[1]), p, 0);
        applyStimulus(1, C1_PT, C1_KEY, 1'b1, -1, 0, 1'b0, 0);
        drainBlock(1, C1_CT, C1_PT, 2);

`ifdef AES_STREAM_KEY_REUSE_EN
        $display("[TB] key reuse");
        applyStimulus(0, C1_PT, C1_KEY, 1'b1, -1, 0, 1'b0, 0);
        drainBlock(0, C1_CT, C1_PT, 0);
        applyStimulus(0, C1_PT, {16{8'hff}}, 1'b0, -1, 0, 1'b0, 0);
        drainBlock(0, C1_CT, C1_PT, 0);
`endif

        $display("[TB] randomized blocks");
        for (int r = 0; r < 12; r++) begin
            sel = r % 2;
            p = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            kl = REUSE ? 1'($urandom_range(1)) : 1'b1;
            applyStimulus(sel, p, k, kl, -1, 0, 1'b1, 0);
            drainBlock(sel, coreFunc(p, key_eff[sel]), p, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
